la_capture_ctrl: RTL

- Write-side controller for the logic-analyzer sample RAM (la_ram). It drives wr_en/wr_addr/wr_data into the RAM's write port.
- It captures probe samples into a circular buffer: pre-trigger fill, then wait for trigger, then post-trigger fill, then stop.
- It reports the trigger address and the oldest-sample address so the read side can unroll the buffer in time order.

---
 rtl/la_capture_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/la_capture_ctrl.sv
// Write-side capture controller for the logic-analyzer sample RAM: circular pre-trigger fill, trigger wait, post fill.
// Build option: define LA_CAPTURE_EDGE_TRIG_EN to accept only rising matches (edge trigger) instead of level matches.
module la_capture_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] probe,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  match;
  logic                  accept;
  logic                  sampling;

  assign match     = ((probe ^ trig_value) & trig_mask) == '0;
  assign sampling  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  // The first sample after arm lands on address 0; later samples advance from the last written one.
  assign next_addr = wr_en ? ADDR_WIDTH'(wr_addr + ONE) : wr_addr;

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  logic prev_match;
  assign accept = match & ~prev_match;
`else
  assign accept = match;
`endif

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state      <= S_IDLE;
      pre_q      <= '0;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
      prev_match <= 1'b0;
`endif
    end else if (busy && abort) begin
      state <= S_IDLE;
      wr_en <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (sampling) begin
        wr_data <= probe;
        wr_en   <= 1'b1;
        wr_addr <= next_addr;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        prev_match <= match;
`endif
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (busy) begin
            // Last write is committing this edge; publish the completed capture.
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            start_addr <= ADDR_WIDTH'(trig_addr - pre_q);
          end else if (arm) begin
            // pre_len is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1.
            pre_q      <= pre_len;
            cnt        <= pre_len;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
            state      <= (pre_len == '0) ? S_WAIT : S_PRE;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
            prev_match <= 1'b0;
`endif
          end
        end
        S_PRE: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) state <= S_WAIT;
        end
        S_WAIT: begin
          if (accept) begin
            trig_addr <= next_addr;
            triggered <= 1'b1;
            cnt       <= LAST - pre_q;
            state     <= (pre_q == LAST) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
